// File: rtl/scaled_timer_pkg.sv
// Shared types and BCD helpers for the scaled per-round countdown timer.
package scaled_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [3:0] MAX_SCALE = 4'd9;
    localparam logic [6:0] WARN_SEC  = 7'd3;

    // Two-digit BCD decrement; saturates at 00 so the display never wraps.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        if (tens == 4'd0 && ones == 4'd0)
            return 8'h00;
        else if (ones == 4'd0)
            return {tens - 4'd1, 4'd9};
        else
            return {tens, ones - 4'd1};
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

endpackage

// File: rtl/scaled_digit_timer_if.sv
// Control/display bundle between the game controller and the round timer.
// The warn signal exists only when SCALED_TIMER_WARN_EN is defined.
interface scaled_digit_timer_if;
    logic       start;
    logic       stop;
    logic [3:0] scale_num;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       timeout;
`ifdef SCALED_TIMER_WARN_EN
    logic       warn;
`endif

    modport master (
        output start, stop, scale_num,
        input  tens, ones, running, timeout
`ifdef SCALED_TIMER_WARN_EN
        , input warn
`endif
    );

    modport slave (
        input  start, stop, scale_num,
        output tens, ones, running, timeout
`ifdef SCALED_TIMER_WARN_EN
        , output warn
`endif
    );
endinterface

// File: rtl/sec_tick_gen.sv
// Prescaler producing a one-cycle tick every TICKS_PER_SEC enabled cycles.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;

    // A clear in the wrap cycle swallows that tick.
    assign tick_o = enable_i && !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (clear_i)
            cnt_q <= '0;
        else if (enable_i)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/scaled_digit_timer.sv
// Per-round BCD countdown timer; load value shrinks with the scale level.
// Optional warn output enabled by defining SCALED_TIMER_WARN_EN.
module scaled_digit_timer
    import scaled_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int BASE_SEC      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    scaled_digit_timer_if.slave   bus
);
    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic       running_q, timeout_q, timeout_d;
    logic       load, halt, tick;
    logic [3:0] scale_clamped;
    logic [6:0] load_bin;
    logic [7:0] load_bcd, dec_bcd;

    // stop dominates start in every state; it only changes state from RUN.
    assign halt          = bus.stop && (state_q == RUN);
    assign load          = bus.start && !bus.stop;
    assign scale_clamped = (bus.scale_num > MAX_SCALE) ? MAX_SCALE : bus.scale_num;
    assign load_bin      = 7'(BASE_SEC) - {3'b000, scale_clamped};
    assign load_bcd      = bin2bcd(load_bin);
    assign dec_bcd       = bcd_dec(tens_q, ones_q);

    sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (load || halt),
        .enable_i (state_q == RUN),
        .tick_o   (tick)
    );

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        timeout_d = 1'b0;
        if (halt) begin
            state_d = IDLE;
        end else if (load) begin
            state_d          = RUN;
            {tens_d, ones_d} = load_bcd;
        end else if (state_q == RUN && tick) begin
            {tens_d, ones_d} = dec_bcd;
            if (tens_q == 4'd0 && ones_q == 4'd1) begin
                state_d   = EXPIRED;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= (state_d == RUN);
            timeout_q <= timeout_d;
        end
    end

    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.running = running_q;
    assign bus.timeout = timeout_q;

`ifdef SCALED_TIMER_WARN_EN
    logic warn_q;

    always_ff @(posedge clk) begin
        if (!rst)
            warn_q <= 1'b0;
        else
            warn_q <= (state_d == RUN) && (tens_d == 4'd0) && ({3'b000, ones_d} <= WARN_SEC);
    end

    assign bus.warn = warn_q;
`endif
endmodule

// File: tb/tb_scaled_digit_timer.sv
// Directed scoreboard bench for scaled_digit_timer at TICKS_PER_SEC=4, BASE_SEC=12.
module tb_scaled_digit_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scaled_digit_timer_if bus();

    scaled_digit_timer #(.TICKS_PER_SEC(4), .BASE_SEC(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       running;
        logic       timeout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Queue the expectation, let n rising edges pass (inputs drop after the first), then compare.
    task automatic check_after(input int n, input string tag, input logic [3:0] t,
                               input logic [3:0] o, input logic r, input logic to);
        exp_t e;
        logic [9:0] got, exp;
        sb.push_back('{tag, t, o, r, to});
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        rst       = 1'b1;
        repeat (n - 1) @(negedge clk);
        e   = sb.pop_front();
        got = {bus.tens, bus.ones, bus.running, bus.timeout};
        exp = {e.tens, e.ones, e.running, e.timeout};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got tens/ones/run/to=%h expected=%h", e.tag, got, exp);
        end
`ifdef SCALED_TIMER_WARN_EN
        checks++;
        assert (bus.warn === (e.running && e.tens == 4'd0 && e.ones <= 4'd3)) else begin
            errors++;
            $error("FAIL %s_warn got=%b", e.tag, bus.warn);
        end
`endif
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.scale_num = 4'd0;
        rst           = 1'b0;
        @(negedge clk);
        check_after(2, "reset", 4'd0, 4'd0, 1'b0, 1'b0);

        // Full countdown from 12
        bus.scale_num = 4'd0; bus.start = 1'b1;
        check_after(1,  "load12",  4'd1, 4'd2, 1'b1, 1'b0);
        check_after(4,  "tick11",  4'd1, 4'd1, 1'b1, 1'b0);
        check_after(32, "at03",    4'd0, 4'd3, 1'b1, 1'b0);
        check_after(11, "at01",    4'd0, 4'd1, 1'b1, 1'b0);
        check_after(1,  "expire",  4'd0, 4'd0, 1'b0, 1'b1);
        check_after(1,  "pulse1",  4'd0, 4'd0, 1'b0, 1'b0);
        check_after(5,  "exphold", 4'd0, 4'd0, 1'b0, 1'b0);
        bus.stop = 1'b1;
        check_after(1,  "stopexp", 4'd0, 4'd0, 1'b0, 1'b0);

        // Scale clamping and mid-run scale change
        bus.scale_num = 4'd9; bus.start = 1'b1;
        check_after(1, "load_s9",   4'd0, 4'd3, 1'b1, 1'b0);
        bus.scale_num = 4'd15; bus.start = 1'b1;
        check_after(1, "load_s15",  4'd0, 4'd3, 1'b1, 1'b0);
        bus.scale_num = 4'd0;
        check_after(4, "scale_mid", 4'd0, 4'd2, 1'b1, 1'b0);
        bus.stop = 1'b1;
        check_after(1, "stop02",    4'd0, 4'd2, 1'b0, 1'b0);

        // BCD borrow and stop hold
        bus.scale_num = 4'd2; bus.start = 1'b1;
        check_after(1, "load10", 4'd1, 4'd0, 1'b1, 1'b0);
        check_after(4, "borrow", 4'd0, 4'd9, 1'b1, 1'b0);
        check_after(8, "at07",   4'd0, 4'd7, 1'b1, 1'b0);
        bus.stop = 1'b1;
        check_after(1, "stop07", 4'd0, 4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            check_after(1, "hold07", 4'd0, 4'd7, 1'b0, 1'b0);

        // Stop in the tick cycle discards the tick
        bus.scale_num = 4'd2; bus.start = 1'b1;
        check_after(1, "reload10", 4'd1, 4'd0, 1'b1, 1'b0);
        check_after(3, "pretick",  4'd1, 4'd0, 1'b1, 1'b0);
        bus.stop = 1'b1;
        check_after(1, "stoptick", 4'd1, 4'd0, 1'b0, 1'b0);
        check_after(6, "tickhold", 4'd1, 4'd0, 1'b0, 1'b0);

        // start+stop together: stop wins in RUN and in IDLE
        bus.scale_num = 4'd4; bus.start = 1'b1;
        check_after(1, "load08", 4'd0, 4'd8, 1'b1, 1'b0);
        check_after(2, "run08",  4'd0, 4'd8, 1'b1, 1'b0);
        bus.start = 1'b1; bus.stop = 1'b1;
        check_after(1, "ss_run",  4'd0, 4'd8, 1'b0, 1'b0);
        bus.start = 1'b1; bus.stop = 1'b1;
        check_after(1, "ss_idle", 4'd0, 4'd8, 1'b0, 1'b0);
        check_after(6, "ss_hold", 4'd0, 4'd8, 1'b0, 1'b0);

        // Restart mid-run reloads and restarts the prescaler
        bus.scale_num = 4'd7; bus.start = 1'b1;
        check_after(1, "load05",  4'd0, 4'd5, 1'b1, 1'b0);
        check_after(2, "run05",   4'd0, 4'd5, 1'b1, 1'b0);
        bus.scale_num = 4'd0; bus.start = 1'b1;
        check_after(1, "restart", 4'd1, 4'd2, 1'b1, 1'b0);
        check_after(3, "pre_rs",  4'd1, 4'd2, 1'b1, 1'b0);
        check_after(1, "post_rs", 4'd1, 4'd1, 1'b1, 1'b0);

        // Reset during RUN
        bus.scale_num = 4'd4; bus.start = 1'b1;
        check_after(1, "r_load08", 4'd0, 4'd8, 1'b1, 1'b0);
        check_after(1, "r_run08",  4'd0, 4'd8, 1'b1, 1'b0);
        rst = 1'b0;
        check_after(1, "rst_mid",  4'd0, 4'd0, 1'b0, 1'b0);
        check_after(8, "rst_idle", 4'd0, 4'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scaled_digit_timer.md
Name: scaled_digit_timer

Overview:
Consumer end of the time-scaling interface: a per-round countdown timer for the memory sequence game.
- Samples the 0..9 scale level on start and loads BASE_SEC minus level seconds.
- Counts down in BCD once per second and drives the two display digits.
- Issues a one-cycle timeout pulse to the game controller when the count reaches 00.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per one-second decrement; legal range >= 2.
BASE_SEC, 12, seconds loaded at scale level 0; legal range 10..99.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse; loads the timer and begins the countdown
stop  input  1  one-cycle pulse; freezes the countdown and returns to IDLE
scale_num  input  4  scale level from the time-scaling block; sampled only on accepted start
tens  output  4  BCD tens digit of seconds remaining
ones  output  4  BCD ones digit of seconds remaining
running  output  1  high while state is RUN
timeout  output  1  one-cycle pulse when the count reaches 00

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset is rst, synchronous, active-low.
- Reset values: state=IDLE, tens=0, ones=0, running=0, timeout=0, prescaler=0.
- States: IDLE, RUN, EXPIRED. running is registered and equals (state==RUN).
- Load value = BASE_SEC - min(scale_num, 9). scale_num values 10..15 clamp to 9. Binary-to-BCD conversion happens at load.
- IDLE or EXPIRED, start=1: next cycle state=RUN, digits=load value, prescaler=0. Load latency is 1 cycle.
- RUN:
  - prescaler counts 0..TICKS_PER_SEC-1. The wrap cycle is the tick.
  - On tick, decrement BCD: ones 0 -> 9 with tens-1; otherwise ones-1.
  - On tick with digits 01: digits become 00, state=EXPIRED, and timeout=1 in the same registered cycle that digits show 00.
  - timeout is high for exactly one cycle.
- RUN, start=1 without stop: restart. Reload from the current scale_num, prescaler=0, and no timeout is generated.
- RUN, stop=1: state=IDLE and digits freeze at their current value. A pending tick in that cycle is discarded.
- start and stop in the same cycle: stop wins. The state goes to IDLE or stays there, and start is ignored.
- stop in IDLE or EXPIRED: no effect. Digits hold.
- EXPIRED: digits hold at 00 and timeout stays low. Only start or reset leave this state.
- scale_num changing mid-RUN: no effect on the current countdown.
- Reset mid-RUN: everything returns to reset values on the next edge, with no timeout pulse.
- Digits never underflow below 00 and never exceed BASE_SEC.

Optional Feature:
SCALED_TIMER_WARN_EN
- Defined: adds output port warn (1 bit), registered. warn=1 while state==RUN and the remaining value is <= 03. Reset value 0, and it clears on the same edge that leaves RUN.
- Undefined: the warn port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package scaled_timer_pkg holds:
  - state typedef (IDLE, RUN, EXPIRED)
  - MAX_SCALE=4'd9
  - WARN_SEC=7'd3
  - a BCD-decrement function
  - a binary(0..99)-to-BCD function
- Natural sub-module sec_tick_gen, parameterised by TICKS_PER_SEC:
  - inputs: clk, rst, clear, enable
  - output: one-cycle tick
  - the top instantiates it with enable=(state==RUN) and clear asserted on load or stop.

Test Plan (TICKS_PER_SEC=4, BASE_SEC=12):
- Reset then start with scale_num=0 -> next cycle running=1, tens=1, ones=2. After 4 cycles, 11. After 48 cycles total, 00 with timeout high for 1 cycle and running=0.
- start with scale_num=9 -> loads 03. scale_num=15 -> also loads 03. Change scale_num mid-run -> count unaffected.
- Count at 10 plus one tick -> 09 (BCD borrow). Stop at 07 -> running=0 and digits hold 07 for 20 cycles with no timeout.
- start and stop in the same cycle while in RUN -> IDLE with digits held. start mid-run at 05 -> reload 12, prescaler restarts, no timeout.
- Drop rst=0 for 1 cycle during RUN at 08 -> next edge digits=00, running=0, timeout=0. Releasing rst -> stays IDLE.
- With SCALED_TIMER_WARN_EN defined -> warn rises when the count becomes 03 and falls on the timeout cycle. With it undefined -> the port is absent.
